// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ
// byte producers. Multi-byte packets stay contiguous via a grant lock
// that is dropped if the owner stays silent for LOCK_TO clocks.
module uart_tx_arbiter #(
  parameter int          N_REQ      = 4,
  parameter logic [9:0]  GAP_CYCLES = 10'd0,
  parameter logic [19:0] LOCK_TO    = 20'd868000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  input  logic               tx_ready,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic               locked,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [19:0]        r_lock_cnt;
  logic [9:0]         r_gap_cnt;
  logic [N_REQ-1:0]   r_grant;
  logic               r_locked;
  logic               r_busy;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic [N_REQ-1:0]   r_req_ack;

  // Candidate requester indices in search order: ptr+1, ptr+2, ... mod N_REQ
  logic [PW-1:0]      w_cand [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [PW:0] w_sum;
      assign w_sum       = {1'b0, r_ptr} + (PW+1)'(gi + 1);
      assign w_cand[gi]  = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ))
                                                      : w_sum[PW-1:0];
    end
  endgenerate

  logic [PW-1:0]      w_win;
  logic               w_any;

  // Round-robin pick: lowest search offset with a valid request wins
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_vld[w_cand[k]]) begin
        w_any = 1'b1;
        w_win = w_cand[k];
      end
    end
  end

  // While locked only the owner (held in r_ptr) may be served
  logic [PW-1:0]      w_sel;
  logic               w_sel_vld;
  logic [7:0]         w_sel_data;
  logic [N_REQ-1:0]   w_sel_onehot;

  assign w_sel        = r_locked ? r_ptr : w_win;
  assign w_sel_vld    = r_locked ? req_vld[r_ptr] : w_any;
  assign w_sel_data   = req_data[{w_sel, 3'b000} +: 8];
  assign w_sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;

  // Main scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= PW'(N_REQ - 1);
      r_lock_cnt <= '0;
      r_gap_cnt  <= '0;
      r_grant    <= '0;
      r_locked   <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_req_ack  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_req_ack  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_sel_vld && tx_ready) begin
            r_tx_data  <= w_sel_data;
            r_grant    <= w_sel_onehot;
            r_ptr      <= w_sel;
            r_locked   <= ~req_last[w_sel];
            r_lock_cnt <= '0;
            r_tx_start <= 1'b1;
            r_req_ack  <= w_sel_onehot;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end else if (r_locked && !req_vld[r_ptr]) begin
            // Silent owner: drop the lock once the timeout expires
            if (r_lock_cnt == LOCK_TO - 20'd1) begin
              r_locked   <= 1'b0;
              r_grant    <= '0;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 20'd1;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (GAP_CYCLES == 10'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              if (!r_locked) r_grant <= '0;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_CYCLES - 10'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!r_locked) r_grant <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 10'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ack  = r_req_ack;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign grant    = r_grant;
  assign locked   = r_locked;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: producer queues, a simple
// transmitter model and a transaction-level round-robin/lock reference.
module tb_uart_tx_arbiter;

  localparam int          N   = 4;
  localparam logic [9:0]  GAP = 10'd5;
  localparam logic [19:0] LTO = 20'd16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_vld;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic           tx_ready;
  logic           tx_done;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic           locked;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .LOCK_TO(LTO)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack),
    .tx_ready(tx_ready), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data),
    .grant(grant), .locked(locked), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Producer byte queues: {last, data}
  logic [8:0] pbuf [N][256];
  int         phead [N];
  int         ptail [N];

  // Transmitter model and bench control
  logic inflight;
  logic force_nr;
  int   done_cyc;
  int   last_done_cyc;
  int   tx_dly;
  bit   rand_dly;
  bit   chk_gap;
  bit   pend_at_done;

  // Reference model state
  int m_ptr;
  int m_lock_own;
  int iss_log [$];
  int last_iss_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int any_pending();
    for (int i = 0; i < N; i++)
      if (phead[i] != ptail[i]) return 1;
    return 0;
  endfunction

  // Lock owner keeps priority while it still has bytes; otherwise the
  // first non-empty producer after the last winner, in circular order.
  function automatic int model_pick();
    if (m_lock_own >= 0 && phead[m_lock_own] != ptail[m_lock_own]) return m_lock_own;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (phead[idx] != ptail[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [8:0] e;
      e = pbuf[i][phead[i]];
      req_vld[i]         = (phead[i] != ptail[i]);
      req_data[8*i +: 8] = e[7:0];
      req_last[i]        = e[8];
    end
    tx_ready = !inflight && !force_nr;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    pbuf[i][ptail[i]] = {last, d};
    ptail[i]++;
  endtask

  // One clock: sample on the falling edge, check, then update stimulus
  task automatic tick();
    int own;
    logic [8:0] ent;
    @(negedge clk);
    cyc++;
    if (tx_start === 1'b1) begin
      chk("no_overlap", {31'd0, inflight}, 32'd0);
      chk("ready_seen", {31'd0, tx_ready}, 32'd1);
      chk("issue_expected", any_pending(), 32'd1);
      own = model_pick();
      if (own >= 0) begin
        ent = pbuf[own][phead[own]];
        chk("tx_data", {24'd0, tx_data}, {24'd0, ent[7:0]});
        chk("req_ack", {28'd0, req_ack}, 32'd1 << own);
        chk("grant", {28'd0, grant}, 32'd1 << own);
        chk("locked", {31'd0, locked}, {31'd0, ~ent[8]});
        chk("busy", {31'd0, busy}, 32'd1);
        if (chk_gap && pend_at_done && last_done_cyc >= 0)
          chk("gap_spacing", cyc - last_done_cyc, int'(GAP) + 2);
        $display("issue cyc=%0d req=%0d data=%02h last=%0b", cyc, own, ent[7:0], ent[8]);
        iss_log.push_back(own);
        last_iss_cyc = cyc;
        m_ptr        = own;
        m_lock_own   = ent[8] ? -1 : own;
        phead[own]++;
      end
      last_done_cyc = -1;
      inflight = 1'b1;
      done_cyc = cyc + (rand_dly ? int'($urandom_range(2, 30)) : tx_dly);
    end else begin
      chk("ack_quiet", {28'd0, req_ack}, 32'd0);
    end
    tx_done = 1'b0;
    if (inflight && cyc == done_cyc) begin
      tx_done       = 1'b1;
      inflight      = 1'b0;
      last_done_cyc = cyc;
      pend_at_done  = (any_pending() != 0);
    end
    drive();
  endtask

  task automatic wait_issue(input int target, input int budget);
    int b = 0;
    while (iss_log.size() < target && b < budget) begin
      tick();
      b++;
    end
    chk("issue_wait", {31'd0, iss_log.size() >= target}, 32'd1);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int b = 0;
    while (tx_done !== 1'b1 && b < budget) begin
      tick();
      b++;
    end
    chk("done_wait", {31'd0, tx_done === 1'b1}, 32'd1);
    dcyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    tick();
    while (busy !== 1'b0 && b < budget) begin
      tick();
      b++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_bench();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    inflight      = 1'b0;
    force_nr      = 1'b0;
    tx_done       = 1'b0;
    m_ptr         = N - 1;
    m_lock_own    = -1;
    last_done_cyc = -1;
    pend_at_done  = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int d;
    int t0;
    int n_lk;
    int b;
    int clr_cyc;
    int total;
    int exp_rr [5];
    int exp_lk [5];

    exp_rr = '{0, 1, 2, 3, 0};
    exp_lk = '{1, 1, 1, 2, 0};
    tx_dly   = 8;
    rand_dly = 1'b0;
    chk_gap  = 1'b0;
    clear_bench();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_grant",    {28'd0, grant},   32'd0);
    chk("rst_locked",   {31'd0, locked},  32'd0);
    chk("rst_busy",     {31'd0, busy},    32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_req_ack",  {28'd0, req_ack}, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte, long transmit time
    tx_dly = 8680;
    iss_log.delete();
    push(0, 8'hA5, 1'b1);
    drive();
    t0 = cyc;
    wait_issue(1, 10);
    chk("single_latency", last_iss_cyc, t0 + 1);
    wait_done(9000, d);
    chk("single_grant_wait", {28'd0, grant},  32'd1);
    chk("single_busy_wait",  {31'd0, busy},   32'd1);
    chk("single_no_lock",    {31'd0, locked}, 32'd0);
    wait_idle(20);
    chk("single_busy_drop", cyc - d, int'(GAP) + 1);
    chk("single_grant_clr", {28'd0, grant}, 32'd0);

    // Round-robin from a fresh pointer
    do_reset();
    rand_dly = 1'b1;
    chk_gap  = 1'b1;
    iss_log.delete();
    push(0, 8'($urandom), 1'b1);
    push(0, 8'($urandom), 1'b1);
    push(1, 8'($urandom), 1'b1);
    push(2, 8'($urandom), 1'b1);
    push(3, 8'($urandom), 1'b1);
    drive();
    wait_issue(5, 400);
    for (int i = 0; i < 5 && i < iss_log.size(); i++)
      chk("rr_order", iss_log[i], exp_rr[i]);
    wait_done(100, d);
    wait_idle(20);

    // Packet lock keeps requester 1 contiguous
    iss_log.delete();
    push(1, 8'($urandom), 1'b0);
    push(1, 8'($urandom), 1'b0);
    push(1, 8'($urandom), 1'b1);
    push(0, 8'($urandom), 1'b1);
    push(2, 8'($urandom), 1'b1);
    drive();
    wait_issue(5, 400);
    for (int i = 0; i < 5 && i < iss_log.size(); i++)
      chk("lock_order", iss_log[i], exp_lk[i]);
    wait_done(100, d);
    wait_idle(20);

    // Lock timeout: requester 3 goes silent mid-packet
    chk_gap  = 1'b0;
    rand_dly = 1'b0;
    tx_dly   = 6;
    iss_log.delete();
    push(3, 8'($urandom), 1'b0);
    drive();
    wait_issue(1, 20);
    push(0, 8'($urandom), 1'b1);
    drive();
    wait_done(50, d);
    n_lk = 0;
    b    = 0;
    while (b < 100) begin
      tick();
      b++;
      if (busy === 1'b0 && locked === 1'b1) begin
        n_lk++;
        if (n_lk == 1) chk("to_grant_held", {28'd0, grant}, 32'd8);
      end
      if (locked === 1'b0) break;
    end
    clr_cyc = cyc;
    chk("to_idle_clocks", n_lk, int'(LTO));
    chk("to_grant_clr", {28'd0, grant}, 32'd0);
    wait_issue(2, 10);
    if (iss_log.size() >= 2) chk("to_next_req", iss_log[1], 0);
    chk("to_issue_cyc", last_iss_cyc, clr_cyc + 1);
    wait_done(50, d);
    wait_idle(20);

    // Backpressure then gap spacing
    iss_log.delete();
    force_nr = 1'b1;
    push(2, 8'h3C, 1'b1);
    drive();
    repeat (20) tick();
    chk("bp_no_start", iss_log.size(), 0);
    force_nr = 1'b0;
    drive();
    t0 = cyc;
    wait_issue(1, 10);
    chk("bp_latency", last_iss_cyc, t0 + 1);
    push(2, 8'($urandom), 1'b1);
    drive();
    chk_gap = 1'b1;
    wait_issue(2, 100);
    wait_done(50, d);
    wait_idle(20);

    // Randomised packets on all requesters
    rand_dly = 1'b1;
    iss_log.delete();
    total = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < N; i++) begin
        int len;
        len = int'($urandom_range(1, 3));
        for (int j = 0; j < len; j++)
          push(i, 8'($urandom), (j == len - 1));
        total += len;
      end
    end
    drive();
    wait_issue(total, 4000);
    chk("rand_drained", any_pending(), 32'd0);
    wait_done(100, d);
    wait_idle(20);

    // Asynchronous reset while waiting for tx_done
    chk_gap  = 1'b0;
    rand_dly = 1'b0;
    tx_dly   = 50;
    iss_log.delete();
    push(1, 8'($urandom), 1'b1);
    drive();
    wait_issue(1, 20);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant",    {28'd0, grant},    32'd0);
    chk("arst_locked",   {31'd0, locked},   32'd0);
    chk("arst_busy",     {31'd0, busy},     32'd0);
    chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("arst_tx_data",  {24'd0, tx_data},  32'd0);
    clear_bench();
    @(negedge clk);
    rst = 1'b0;
    iss_log.delete();
    push(2, 8'($urandom), 1'b1);
    push(0, 8'($urandom), 1'b1);
    drive();
    wait_issue(2, 200);
    if (iss_log.size() >= 2) begin
      chk("arst_first", iss_log[0], 0);
      chk("arst_second", iss_log[1], 2);
    end
    wait_done(100, d);
    wait_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
